// File: rtl/stage_pkg.sv
// stage_pkg
// Shared definitions for the multi-board game-stage controller:
//   - stage_state_t : 3-bit state codes, which also drive VGA/LED directly
//   - MAX_PEERS     : widest peer set the winner encoder understands
//   - WINNER_LOCAL  : winner_id value meaning "this board finished first"
//   - first_peer_id : maps a finish vector to 1 + lowest set index (0 if none)
package stage_pkg;

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_WAIT_LINK = 3'd1,
        ST_LINKED    = 3'd2,
        ST_PLAY      = 3'd3,
        ST_WIN       = 3'd4,
        ST_LOSE      = 3'd5
    } stage_state_t;

    localparam int         MAX_PEERS    = 7;
    localparam logic [2:0] WINNER_LOCAL = 3'd0;

    // Lowest index wins so simultaneous remote finishes resolve deterministically.
    function automatic logic [2:0] first_peer_id(input logic [MAX_PEERS-1:0] finish_vec);
        logic [2:0] id;
        id = WINNER_LOCAL;
        for (int i = MAX_PEERS - 1; i >= 0; i--) begin
            if (finish_vec[i]) begin
                id = 3'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/link_filter.sv
// link_filter
// Brings one asynchronous inter-board wire into the clk domain and removes
// glitches: a SYNC_STAGES flop chain followed by a stability counter that
// only lets the filtered value follow the synced value after it has differed
// for FILTER_CYCLES consecutive cycles.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   rx_async     : raw peer wire
//   rx_filtered  : registered, debounced level
import stage_pkg::*;

module link_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_async,
    output logic rx_filtered
);

    localparam int              CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       stable_cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Counter runs only while synced disagrees with the filtered level; any
    // agreement (i.e. a glitch ending early) restarts the qualification.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            stable_cnt  <= '0;
            rx_filtered <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_async};
            if (synced == rx_filtered) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                stable_cnt  <= '0;
                rx_filtered <= synced;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stage_link_ctrl.sv
// stage_link_ctrl
// Game-stage controller for multi-board sudoku play: runs the
// menu/connect/play/result FSM, drives the connect/start/finish wires to the
// peers, times out stalled connects and reports which board finished first.
// Ports:
//   clk, reset                  : system clock, synchronous active-high reset
//   mouse_left                  : mouse left button level (rising edge = click)
//   on_*_btn                    : cursor is over the connect/start/return button
//   local_finish                : local puzzle solved
//   rx_connect/start/finish     : asynchronous wires from each peer
//   tx_connect/start/finish     : wires to the peers
//   game_init                   : one-cycle pulse on entering PLAY
//   is_slave                    : 0 = this board initiated the link
//   state                       : current state code
//   peers_linked                : filtered rx_connect
//   winner_id                   : 0 = local, k = peer k-1 (WIN/LOSE only)
//   timeout                     : one-cycle pulse when a connect attempt expires
import stage_pkg::*;

module stage_link_ctrl #(
    parameter int NUM_PEERS      = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mouse_left,
    input  logic                 on_connect_btn,
    input  logic                 on_start_btn,
    input  logic                 on_return_btn,
    input  logic                 local_finish,
    input  logic [NUM_PEERS-1:0] rx_connect,
    input  logic [NUM_PEERS-1:0] rx_start,
    input  logic [NUM_PEERS-1:0] rx_finish,
    output logic                 tx_connect,
    output logic                 tx_start,
    output logic                 tx_finish,
    output logic                 game_init,
    output logic                 is_slave,
    output logic [2:0]           state,
    output logic [NUM_PEERS-1:0] peers_linked,
    output logic [2:0]           winner_id,
    output logic                 timeout
);

    localparam int            TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    stage_state_t           state_q;
    stage_state_t           state_next;
    logic [NUM_PEERS-1:0]   connect_f;
    logic [NUM_PEERS-1:0]   start_f;
    logic [NUM_PEERS-1:0]   finish_f;
    logic [NUM_PEERS-1:0]   start_prev;
    logic [MAX_PEERS-1:0]   finish_pad;
    logic [TMO_W-1:0]       wait_cnt;
    logic                   mouse_prev;
    logic                   click;
    logic                   start_rise;
    logic                   link_lost;
    logic                   finish_any;
    logic                   timeout_hit;
    logic                   slave_next;
    logic [2:0]             winner_next;

    for (genvar i = 0; i < NUM_PEERS; i++) begin : g_peer
        link_filter #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_connect (
            .clk        (clk),
            .reset      (reset),
            .rx_async   (rx_connect[i]),
            .rx_filtered(connect_f[i])
        );
        link_filter #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_start (
            .clk        (clk),
            .reset      (reset),
            .rx_async   (rx_start[i]),
            .rx_filtered(start_f[i])
        );
        link_filter #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_finish (
            .clk        (clk),
            .reset      (reset),
            .rx_async   (rx_finish[i]),
            .rx_filtered(finish_f[i])
        );
    end

    // Filter outputs are already flops, so they serve directly as the output.
    assign peers_linked = connect_f;
    assign state        = state_q;

    assign click      = mouse_left & ~mouse_prev;
    assign start_rise = |(start_f & ~start_prev);
    assign link_lost  = ~&connect_f;
    assign finish_any = |finish_f;

    always_comb begin
        finish_pad                 = '0;
        finish_pad[NUM_PEERS-1:0]  = finish_f;
    end

    always_comb begin
        state_next  = state_q;
        timeout_hit = 1'b0;
        slave_next  = is_slave;
        winner_next = winner_id;
        case (state_q)
            ST_MENU: begin
                // A local click beats a simultaneous remote connect: we become master.
                if (click && on_connect_btn) begin
                    state_next = ST_WAIT_LINK;
                    slave_next = 1'b0;
                end else if (|connect_f) begin
                    state_next = ST_WAIT_LINK;
                    slave_next = 1'b1;
                end
            end
            ST_WAIT_LINK: begin
                if (&connect_f) begin
                    state_next = ST_LINKED;
                end else if (click && on_return_btn) begin
                    state_next = ST_MENU;
                end else if (wait_cnt == TMO_LAST) begin
                    state_next  = ST_MENU;
                    timeout_hit = 1'b1;
                end
            end
            ST_LINKED: begin
                if (link_lost || (click && on_return_btn)) begin
                    state_next = ST_MENU;
                end else if (!is_slave && click && on_start_btn) begin
                    state_next = ST_PLAY;
                end else if (is_slave && start_rise) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Losing the link makes any finish result meaningless, so it is checked first.
                if (link_lost) begin
                    state_next = ST_MENU;
                end else if (local_finish && finish_any) begin
                    if (is_slave) begin
                        state_next  = ST_LOSE;
                        winner_next = first_peer_id(finish_pad);
                    end else begin
                        state_next  = ST_WIN;
                        winner_next = WINNER_LOCAL;
                    end
                end else if (local_finish) begin
                    state_next  = ST_WIN;
                    winner_next = WINNER_LOCAL;
                end else if (finish_any) begin
                    state_next  = ST_LOSE;
                    winner_next = first_peer_id(finish_pad);
                end
            end
            ST_WIN, ST_LOSE: begin
                if (click && on_return_btn) begin
                    state_next = ST_MENU;
                end
            end
            default: begin
                state_next = ST_MENU;
            end
        endcase
        if (state_next == ST_MENU) begin
            slave_next = 1'b0;
        end
        if (state_next != ST_WIN && state_next != ST_LOSE) begin
            winner_next = WINNER_LOCAL;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register, including dropping on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_MENU;
            mouse_prev <= 1'b0;
            start_prev <= '0;
            wait_cnt   <= '0;
            tx_connect <= 1'b0;
            tx_start   <= 1'b0;
            tx_finish  <= 1'b0;
            game_init  <= 1'b0;
            timeout    <= 1'b0;
            is_slave   <= 1'b0;
            winner_id  <= WINNER_LOCAL;
        end else begin
            state_q    <= state_next;
            mouse_prev <= mouse_left;
            start_prev <= start_f;
            // Any stay in WAIT_LINK counts up; anything else leaves it cleared for the next entry.
            if (state_q == ST_WAIT_LINK && state_next == ST_WAIT_LINK) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            tx_connect <= (state_next != ST_MENU);
            tx_start   <= (state_next == ST_PLAY) || (state_next == ST_WIN) || (state_next == ST_LOSE);
            tx_finish  <= (state_next == ST_WIN);
            game_init  <= (state_next == ST_PLAY) && (state_q != ST_PLAY);
            timeout    <= timeout_hit;
            is_slave   <= slave_next;
            winner_id  <= winner_next;
        end
    end

endmodule

// File: tb/tb_stage_link_ctrl.sv
// tb_stage_link_ctrl
// Directed bench for stage_link_ctrl with NUM_PEERS=2, SYNC=2, FILTER=4,
// TIMEOUT=50. Expectations are queued as stimulus is applied and popped and
// compared once the clock has advanced to the cycle they describe.
module tb_stage_link_ctrl;

    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mouse_left = 1'b0;
    logic          on_connect_btn = 1'b0;
    logic          on_start_btn = 1'b0;
    logic          on_return_btn = 1'b0;
    logic          local_finish = 1'b0;
    logic [NP-1:0] rx_connect = '0;
    logic [NP-1:0] rx_start = '0;
    logic [NP-1:0] rx_finish = '0;
    logic          tx_connect;
    logic          tx_start;
    logic          tx_finish;
    logic          game_init;
    logic          is_slave;
    logic [2:0]    state;
    logic [NP-1:0] peers_linked;
    logic [2:0]    winner_id;
    logic          timeout;

    int vectors = 0;
    int miscompares = 0;

    typedef enum int {
        SIG_STATE, SIG_TXC, SIG_TXS, SIG_TXF, SIG_INIT,
        SIG_SLAVE, SIG_LINKED, SIG_WINNER, SIG_TIMEOUT
    } sig_t;

    typedef struct {
        string      tag;
        sig_t       sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];

    stage_link_ctrl #(
        .NUM_PEERS     (NP),
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mouse_left    (mouse_left),
        .on_connect_btn(on_connect_btn),
        .on_start_btn  (on_start_btn),
        .on_return_btn (on_return_btn),
        .local_finish  (local_finish),
        .rx_connect    (rx_connect),
        .rx_start      (rx_start),
        .rx_finish     (rx_finish),
        .tx_connect    (tx_connect),
        .tx_start      (tx_start),
        .tx_finish     (tx_finish),
        .game_init     (game_init),
        .is_slave      (is_slave),
        .state         (state),
        .peers_linked  (peers_linked),
        .winner_id     (winner_id),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] observe(input sig_t sel);
        case (sel)
            SIG_STATE:   return {5'd0, state};
            SIG_TXC:     return {7'd0, tx_connect};
            SIG_TXS:     return {7'd0, tx_start};
            SIG_TXF:     return {7'd0, tx_finish};
            SIG_INIT:    return {7'd0, game_init};
            SIG_SLAVE:   return {7'd0, is_slave};
            SIG_LINKED:  return {6'd0, peers_linked};
            SIG_WINNER:  return {5'd0, winner_id};
            default:     return {7'd0, timeout};
        endcase
    endfunction

    task automatic expect_val(input string tag, input sig_t sel, input logic [7:0] exp);
        sb.push_back('{tag, sel, exp});
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic apply_stimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output();
        exp_t       e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic click(input int btn);
        on_connect_btn = (btn == 0);
        on_start_btn   = (btn == 1);
        on_return_btn  = (btn == 2);
        mouse_left     = 1'b1;
    endtask

    task automatic release_mouse();
        mouse_left     = 1'b0;
        on_connect_btn = 1'b0;
        on_start_btn   = 1'b0;
        on_return_btn  = 1'b0;
    endtask

    initial begin
        // Reset
        apply_stimulus(3);
        expect_val("rst_state", SIG_STATE, 8'd0);
        expect_val("rst_txc", SIG_TXC, 8'd0);
        expect_val("rst_txs", SIG_TXS, 8'd0);
        expect_val("rst_txf", SIG_TXF, 8'd0);
        expect_val("rst_linked", SIG_LINKED, 8'd0);
        expect_val("rst_init", SIG_INIT, 8'd0);
        expect_val("rst_slave", SIG_SLAVE, 8'd0);
        expect_val("rst_timeout", SIG_TIMEOUT, 8'd0);
        check_output();
        reset = 1'b0;
        apply_stimulus(1);

        // Master connect and start
        click(0);
        apply_stimulus(1);
        expect_val("m_wait_state", SIG_STATE, 8'd1);
        expect_val("m_wait_txc", SIG_TXC, 8'd1);
        expect_val("m_wait_slave", SIG_SLAVE, 8'd0);
        check_output();
        release_mouse();
        rx_connect = 2'b11;
        apply_stimulus(5);
        expect_val("m_link_early", SIG_LINKED, 8'd0);
        check_output();
        apply_stimulus(1);
        expect_val("m_link_6", SIG_LINKED, 8'd3);
        expect_val("m_link_6_state", SIG_STATE, 8'd1);
        check_output();
        apply_stimulus(1);
        expect_val("m_linked_state", SIG_STATE, 8'd2);
        expect_val("m_linked_txs", SIG_TXS, 8'd0);
        check_output();
        click(1);
        apply_stimulus(1);
        expect_val("m_play_state", SIG_STATE, 8'd3);
        expect_val("m_play_init", SIG_INIT, 8'd1);
        expect_val("m_play_txs", SIG_TXS, 8'd1);
        check_output();
        release_mouse();
        apply_stimulus(1);
        expect_val("m_play_init_once", SIG_INIT, 8'd0);
        expect_val("m_play_hold", SIG_STATE, 8'd3);
        check_output();

        // Reset mid-game drops everything on the same edge
        rx_connect = 2'b00;
        reset = 1'b1;
        apply_stimulus(1);
        expect_val("midrst_state", SIG_STATE, 8'd0);
        expect_val("midrst_txc", SIG_TXC, 8'd0);
        expect_val("midrst_txs", SIG_TXS, 8'd0);
        check_output();
        reset = 1'b0;
        apply_stimulus(1);

        // Glitch rejection and connect timeout
        click(0);
        apply_stimulus(1);
        expect_val("to_wait", SIG_STATE, 8'd1);
        check_output();
        release_mouse();
        rx_connect = 2'b01;
        apply_stimulus(3);
        rx_connect = 2'b00;
        apply_stimulus(45);
        expect_val("glitch_linked", SIG_LINKED, 8'd0);
        expect_val("to_48_state", SIG_STATE, 8'd1);
        expect_val("to_48_pulse", SIG_TIMEOUT, 8'd0);
        check_output();
        apply_stimulus(1);
        expect_val("to_49_state", SIG_STATE, 8'd1);
        check_output();
        apply_stimulus(1);
        expect_val("to_50_state", SIG_STATE, 8'd0);
        expect_val("to_50_pulse", SIG_TIMEOUT, 8'd1);
        expect_val("to_50_txc", SIG_TXC, 8'd0);
        check_output();
        apply_stimulus(1);
        expect_val("to_pulse_once", SIG_TIMEOUT, 8'd0);
        check_output();

        // Return from WAIT_LINK
        click(0);
        apply_stimulus(1);
        release_mouse();
        apply_stimulus(1);
        click(2);
        apply_stimulus(1);
        expect_val("ret_wait_state", SIG_STATE, 8'd0);
        check_output();
        release_mouse();

        // Slave path
        rx_connect = 2'b11;
        apply_stimulus(6);
        expect_val("s_linked", SIG_LINKED, 8'd3);
        expect_val("s_menu", SIG_STATE, 8'd0);
        check_output();
        apply_stimulus(1);
        expect_val("s_wait", SIG_STATE, 8'd1);
        expect_val("s_slave", SIG_SLAVE, 8'd1);
        expect_val("s_txc", SIG_TXC, 8'd1);
        check_output();
        apply_stimulus(1);
        expect_val("s_linked_state", SIG_STATE, 8'd2);
        check_output();
        rx_start = 2'b10;
        apply_stimulus(6);
        expect_val("s_start_early", SIG_STATE, 8'd2);
        check_output();
        apply_stimulus(1);
        expect_val("s_play", SIG_STATE, 8'd3);
        expect_val("s_init", SIG_INIT, 8'd1);
        check_output();
        apply_stimulus(1);
        expect_val("s_init_once", SIG_INIT, 8'd0);
        check_output();

        // Finish race as slave
        rx_finish = 2'b10;
        apply_stimulus(6);
        expect_val("s_race_hold", SIG_STATE, 8'd3);
        check_output();
        local_finish = 1'b1;
        apply_stimulus(1);
        expect_val("s_race_state", SIG_STATE, 8'd5);
        expect_val("s_race_winner", SIG_WINNER, 8'd2);
        expect_val("s_race_txf", SIG_TXF, 8'd0);
        expect_val("s_race_txs", SIG_TXS, 8'd1);
        check_output();

        // Master re-link where click coincides with remote connect
        local_finish = 1'b0;
        rx_finish = 2'b00;
        rx_start = 2'b00;
        reset = 1'b1;
        apply_stimulus(2);
        reset = 1'b0;
        apply_stimulus(6);
        expect_val("tie_linked", SIG_LINKED, 8'd3);
        expect_val("tie_menu", SIG_STATE, 8'd0);
        check_output();
        click(0);
        apply_stimulus(1);
        expect_val("tie_wait", SIG_STATE, 8'd1);
        expect_val("tie_master", SIG_SLAVE, 8'd0);
        check_output();
        release_mouse();
        apply_stimulus(1);
        click(1);
        apply_stimulus(1);
        expect_val("m2_play", SIG_STATE, 8'd3);
        check_output();
        release_mouse();

        // Finish race as master
        rx_finish = 2'b10;
        apply_stimulus(6);
        local_finish = 1'b1;
        apply_stimulus(1);
        expect_val("m_race_state", SIG_STATE, 8'd4);
        expect_val("m_race_winner", SIG_WINNER, 8'd0);
        expect_val("m_race_txf", SIG_TXF, 8'd1);
        check_output();
        local_finish = 1'b0;
        rx_finish = 2'b00;
        click(2);
        apply_stimulus(1);
        expect_val("win_ret_state", SIG_STATE, 8'd0);
        expect_val("win_ret_txf", SIG_TXF, 8'd0);
        check_output();
        release_mouse();

        // Peers still linked, so MENU re-enters as slave; then link loss in PLAY
        apply_stimulus(2);
        expect_val("ll_linked_state", SIG_STATE, 8'd2);
        check_output();
        rx_start = 2'b01;
        apply_stimulus(7);
        expect_val("ll_play", SIG_STATE, 8'd3);
        check_output();
        rx_connect = 2'b01;
        apply_stimulus(6);
        expect_val("ll_hold", SIG_STATE, 8'd3);
        expect_val("ll_linked", SIG_LINKED, 8'd1);
        check_output();
        apply_stimulus(1);
        expect_val("ll_menu", SIG_STATE, 8'd0);
        expect_val("ll_txc", SIG_TXC, 8'd0);
        expect_val("ll_txs", SIG_TXS, 8'd0);
        check_output();
        apply_stimulus(1);
        expect_val("ll_rewait", SIG_STATE, 8'd1);
        check_output();
        reset = 1'b1;
        apply_stimulus(1);
        expect_val("wait_rst_state", SIG_STATE, 8'd0);
        expect_val("wait_rst_txc", SIG_TXC, 8'd0);
        expect_val("wait_rst_linked", SIG_LINKED, 8'd0);
        check_output();
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
